// File: rtl/control_frame_loader.sv
// -----------------------------------------------------------------------------
// control_frame_loader
//
// Streams one control frame (NUM_BLOCKS words) from a valid/ready source into
// the block-addressed control combiner. Each accepted word is written one cycle
// later to the next block address. A complete, correctly framed frame ends with
// a one-cycle frame_done pulse, which downstream logic uses as its "apply"
// strobe. Framing problems raise a one-cycle frame_err pulse with a cause code.
//
// Optional feature (compile-time macro CTRL_LOADER_CHECKSUM_EN):
//   A trailing checksum word follows the data words. It is compared against
//   the running sum (mod 2^WORD_W) of the frame's data words and is never
//   written to the combiner. Without the macro there is no CHECK state and no
//   sum register, and a frame is exactly NUM_BLOCKS words.
//
// Ports
//   clk          in   1       system clock, all logic on posedge
//   rst_n        in   1       synchronous reset, active-low
//   s_data       in   WORD_W  input word
//   s_valid      in   1       s_data valid
//   s_sof        in   1       start-of-frame marker (qualified by s_valid)
//   s_ready      out  1       loader can accept a word (0 in DONE / reset)
//   signal       out  WORD_W  word to combiner (registered)
//   blockaddress out  ADDR_W  combiner block index (registered)
//   write        out  1       combiner write strobe, one cycle per word
//   frame_done   out  1       pulse: full valid frame written
//   frame_err    out  1       pulse: frame error detected
//   err_code     out  2       last error: 01 stray/resync, 10 timeout,
//                             11 checksum
//   busy         out  1       high while state != IDLE
// -----------------------------------------------------------------------------
module control_frame_loader #(
    parameter int WORD_W     = 16,
    parameter int NUM_BLOCKS = 64,
    parameter int ADDR_W     = 6,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic              s_ready,
    output logic [WORD_W-1:0] signal,
    output logic [ADDR_W-1:0] blockaddress,
    output logic              write,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    // ------------------------------------------------------------------
    // State encoding and error codes
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] ERR_STRAY   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

`ifdef CTRL_LOADER_CHECKSUM_EN
    localparam logic [1:0] ERR_CHECKSUM = 2'b11;
    // After the last data word the checksum word is still outstanding.
    localparam logic [1:0] ST_END       = ST_CHECK;
`else
    localparam logic [1:0] ST_END       = ST_DONE;
`endif

    // A single-block frame is complete as soon as its sof word lands.
    localparam logic [1:0] ST_AFTER_SOF = (NUM_BLOCKS == 1) ? ST_END : ST_LOAD;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BLOCKS - 1);

    // Stall counter sized to hold TIMEOUT; TIMEOUT=0 disables the watchdog.
    localparam int              SW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0]   STALL_LAST = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        state_q,  state_d;
    logic [ADDR_W-1:0] index_q,  index_d;
    logic [SW-1:0]     stall_q,  stall_d;
    logic [WORD_W-1:0] signal_q, signal_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              write_q,  write_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;
    logic [1:0]        code_q,   code_d;
    logic              busy_q,   busy_d;
`ifdef CTRL_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q,    sum_d;
`endif

    logic accept;
    logic in_frame;

    // Ready is combinational so that it drops immediately while reset is held.
    assign s_ready  = rst_n & (state_q != ST_DONE);
    assign accept   = s_valid & s_ready;
    assign in_frame = (state_q == ST_LOAD) || (state_q == ST_CHECK);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        stall_d  = '0;
        signal_d = signal_q;
        addr_d   = addr_q;
        write_d  = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
`ifdef CTRL_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif

        if (accept && s_sof) begin
            // sof always (re)starts a frame at block 0, even on the last
            // data word or the checksum word. Outside IDLE it is a resync.
            write_d  = 1'b1;
            signal_d = s_data;
            addr_d   = '0;
            index_d  = ADDR_W'(1);
            state_d  = ST_AFTER_SOF;
`ifdef CTRL_LOADER_CHECKSUM_EN
            sum_d    = s_data;
`endif
            if (state_q != ST_IDLE) begin
                err_d  = 1'b1;
                code_d = ERR_STRAY;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A data word with no frame open is dropped.
                    if (accept) begin
                        err_d  = 1'b1;
                        code_d = ERR_STRAY;
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        write_d  = 1'b1;
                        signal_d = s_data;
                        addr_d   = index_q;
                        index_d  = index_q + ADDR_W'(1);
`ifdef CTRL_LOADER_CHECKSUM_EN
                        sum_d    = sum_q + s_data;
`endif
                        if (index_q == LAST_IDX) begin
                            state_d = ST_END;
                        end
                    end
                end

                ST_CHECK: begin
`ifdef CTRL_LOADER_CHECKSUM_EN
                    // Checksum word: compared only, never written.
                    if (accept) begin
                        if (s_data == sum_q) begin
                            state_d = ST_DONE;
                        end else begin
                            err_d   = 1'b1;
                            code_d  = ERR_CHECKSUM;
                            state_d = ST_IDLE;
                            index_d = '0;
                        end
                    end
`else
                    state_d = ST_IDLE;
`endif
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                    index_d = '0;
                end

                default: begin
                    state_d = ST_IDLE;
                    index_d = '0;
                end
            endcase
        end

        // Mid-frame watchdog. An accept in the cycle that would reach the
        // limit clears the counter instead of firing.
        if (in_frame && !accept && (TIMEOUT > 0)) begin
            if (stall_q == STALL_LAST) begin
                state_d = ST_IDLE;
                index_d = '0;
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
            end else begin
                stall_d = stall_q + SW'(1);
            end
        end

        // frame_done and busy are registered alongside the state so they
        // line up exactly with the DONE / non-IDLE cycles.
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            index_q  <= '0;
            stall_q  <= '0;
            signal_q <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
            busy_q   <= 1'b0;
`ifdef CTRL_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            stall_q  <= stall_d;
            signal_q <= signal_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            busy_q   <= busy_d;
`ifdef CTRL_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign signal       = signal_q;
    assign blockaddress = addr_q;
    assign write        = write_q;
    assign frame_done   = done_q;
    assign frame_err    = err_q;
    assign err_code     = code_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_control_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_control_frame_loader
//
// Directed bench for control_frame_loader (TIMEOUT=16). Expected combiner
// writes {addr,data} are queued as words are driven and popped by a negedge
// monitor whenever the DUT raises write. Status outputs are checked at fixed
// points #1 after the relevant clock edge.
// -----------------------------------------------------------------------------
module tb_control_frame_loader;

    localparam int WORD_W = 16;
    localparam int NB     = 64;
    localparam int AW     = 6;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_sof;
    logic              s_ready;
    logic [WORD_W-1:0] signal;
    logic [AW-1:0]     blockaddress;
    logic              write;
    logic              frame_done;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;

    control_frame_loader #(
        .WORD_W(WORD_W), .NUM_BLOCKS(NB), .ADDR_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .s_sof(s_sof), .s_ready(s_ready), .signal(signal),
        .blockaddress(blockaddress), .write(write), .frame_done(frame_done),
        .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic mon_en = 1'b0;
    logic [AW+WORD_W-1:0] sbq[$];
    logic [WORD_W-1:0]    bsum = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one word for one cycle; wr says whether it should reach the combiner.
    task automatic send(input logic [WORD_W-1:0] d, input logic sof,
                        input logic wr, input logic [AW-1:0] a);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        if (wr) begin
            sbq.push_back({a, d});
            bsum = sof ? d : WORD_W'(bsum + d);
        end
        cyc();
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    // Closes a frame: a checksum word when the feature is built in.
    task automatic end_frame();
`ifdef CTRL_LOADER_CHECKSUM_EN
        send(bsum, 1'b0, 1'b0, '0);
`endif
    endtask

    // Write scoreboard and pulse bookkeeping.
    always @(negedge clk) begin
        if (mon_en) begin
            if (write === 1'b1) begin
                chk("sb_nonempty", 32'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    logic [AW+WORD_W-1:0] e;
                    e = sbq.pop_front();
                    chk("wr_addr", 32'(blockaddress), 32'(e[AW+WORD_W-1:WORD_W]));
                    chk("wr_data", 32'(signal), 32'(e[WORD_W-1:0]));
                end
            end
            if (frame_done === 1'b1) done_cnt++;
            if (frame_err === 1'b1) err_cnt++;
            chk("done_err_excl", 32'(frame_done & frame_err), 0);
        end
    end

    initial begin
        int d0, e0;

        // ---- 1: reset with s_valid held high
        rst_n = 1'b0; s_valid = 1'b1; s_sof = 1'b1; s_data = 16'h1234;
        cyc(2);
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_write", 32'(write), 0);
        chk("rst_signal", 32'(signal), 0);
        chk("rst_addr", 32'(blockaddress), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_code", 32'(err_code), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1; s_valid = 1'b0; s_sof = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("idle_ready", 32'(s_ready), 1);
        cyc();

        // ---- 2: full back-to-back frame
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < NB; i++) send(16'(16'h1000 + i), i == 0, 1'b1, AW'(i));
        end_frame();
        chk("t2_done", 32'(frame_done), 1);
        chk("t2_ready_in_done", 32'(s_ready), 0);
        chk("t2_busy_in_done", 32'(busy), 1);
        cyc();
        chk("t2_done_clr", 32'(frame_done), 0);
        chk("t2_busy_after", 32'(busy), 0);
        chk("t2_ready_after", 32'(s_ready), 1);
        chk("t2_done_cnt", 32'(done_cnt - d0), 1);
        chk("t2_err_cnt", 32'(err_cnt - e0), 0);

        // ---- 3: stray word then resync at index 20
        d0 = done_cnt; e0 = err_cnt;
        send(16'hBEEF, 1'b0, 1'b0, '0);
        chk("t3_stray_err", 32'(frame_err), 1);
        chk("t3_stray_code", 32'(err_code), 2'b01);
        chk("t3_stray_busy", 32'(busy), 0);
        cyc();
        chk("t3_err_pulse", 32'(frame_err), 0);
        chk("t3_code_hold", 32'(err_code), 2'b01);
        send(16'h2000, 1'b1, 1'b1, '0);
        for (int i = 1; i < 20; i++) send(16'(16'h2000 + i), 1'b0, 1'b1, AW'(i));
        send(16'h0077, 1'b1, 1'b1, '0);
        chk("t3_resync_err", 32'(frame_err), 1);
        chk("t3_resync_code", 32'(err_code), 2'b01);
        chk("t3_resync_busy", 32'(busy), 1);
        for (int i = 1; i < NB; i++) send(16'(16'h0077 + i), 1'b0, 1'b1, AW'(i));
        end_frame();
        chk("t3_done", 32'(frame_done), 1);
        cyc();
        chk("t3_done_cnt", 32'(done_cnt - d0), 1);
        chk("t3_err_cnt", 32'(err_cnt - e0), 2);

        // ---- 4a: 16 stall cycles mid-frame -> timeout
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 10; i++) send(16'(16'h3000 + i), i == 0, 1'b1, AW'(i));
        cyc(TO - 1);
        chk("t4_pre_err", 32'(frame_err), 0);
        chk("t4_pre_busy", 32'(busy), 1);
        cyc();
        chk("t4_to_err", 32'(frame_err), 1);
        chk("t4_to_code", 32'(err_code), 2'b10);
        chk("t4_to_busy", 32'(busy), 0);
        cyc();
        chk("t4_to_pulse", 32'(frame_err), 0);
        chk("t4_to_done_cnt", 32'(done_cnt - d0), 0);

        // ---- 4b: 15 stall cycles then accept -> continues at addr 10
        for (int i = 0; i < 10; i++) send(16'(16'h4000 + i), i == 0, 1'b1, AW'(i));
        cyc(TO - 1);
        chk("t4b_stall_busy", 32'(busy), 1);
        send(16'h400A, 1'b0, 1'b1, AW'(10));
        chk("t4b_no_err", 32'(frame_err), 0);
        chk("t4b_busy", 32'(busy), 1);
        for (int i = 11; i < NB; i++) send(16'(16'h4000 + i), 1'b0, 1'b1, AW'(i));
        end_frame();
        chk("t4b_done", 32'(frame_done), 1);
        cyc();
        chk("t4_err_cnt", 32'(err_cnt - e0), 1);
        chk("t4_code_hold", 32'(err_code), 2'b10);

        // ---- 5: random gaps below the timeout
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < NB; i++) begin
            cyc(int'($urandom_range(0, 8)));
            send(16'(16'h5A00 ^ (i * 7)), i == 0, 1'b1, AW'(i));
        end
        end_frame();
        cyc(2);
        chk("t5_done_cnt", 32'(done_cnt - d0), 1);
        chk("t5_err_cnt", 32'(err_cnt - e0), 0);

`ifdef CTRL_LOADER_CHECKSUM_EN
        // ---- 6: checksum good / bad
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < NB; i++) send(16'(i + 1), i == 0, 1'b1, AW'(i));
        chk("t6_wait_cs", 32'(frame_done), 0);
        send(16'h0820, 1'b0, 1'b0, '0);
        chk("t6_good_done", 32'(frame_done), 1);
        cyc();
        for (int i = 0; i < NB; i++) send(16'(i + 1), i == 0, 1'b1, AW'(i));
        send(16'h0821, 1'b0, 1'b0, '0);
        chk("t6_bad_err", 32'(frame_err), 1);
        chk("t6_bad_code", 32'(err_code), 2'b11);
        chk("t6_bad_done", 32'(frame_done), 0);
        chk("t6_bad_busy", 32'(busy), 0);
        cyc(2);
        chk("t6_done_cnt", 32'(done_cnt - d0), 1);
        chk("t6_err_cnt", 32'(err_cnt - e0), 1);
`endif

        cyc(2);
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
